fifo_ram_param: RTL and testbench

- Parametrised successor to the 8-bit byte FIFO used in the serial/communication datapath.
- Buffers words between a producer and consumer on one clock domain.
- Adds generic width and depth, fill count, almost-full/almost-empty flags, sticky overflow/underflow flags, synchronous flush, and an optional first-word-fall-through (FWFT) read mode.
- Storage is an inferred simple-dual-port RAM.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ram_param_if.sv | 30 +++
 rtl/fifo_ram_dp.sv | 24 ++
 rtl/fifo_ram_param.sv | 127 ++++++++++++
 tb/tb_fifo_ram_param.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, helpers and mode enum for the parametrised FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 14;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ram_param_if.sv
// rtl/fifo_ram_param_if.sv - producer/consumer handshake and status bundle of the FIFO
interface fifo_ram_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic                  enable;
  logic                  flush;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enable, flush, write, data_in, read,
    input  data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  enable, flush, write, data_in, read,
    output data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - simple dual-port RAM, synchronous write and read, read-first
module fifo_ram_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write returns the old word; the full-FIFO read+write case relies on it.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_ram_param.sv
// rtl/fifo_ram_param.sv - parametrised single-clock FIFO with flags, flush and optional FWFT read
module fifo_ram_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  parameter int FWFT               = 0
) (
  input logic             clock,
  input logic             reset_n,
  fifo_ram_param_if.slave bus
);
  localparam int         DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int         CNT_W = clog2(DEPTH + 1);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  valid_q, valid_d, loaded_q, loaded_d;
  logic                  act, head_avail, rd_ok, wr_ok, ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_q;

  // In FWFT mode valid_q marks a prefetched head word held in the RAM output register.
  always_comb begin
    act        = bus.enable & ~bus.flush;
    head_avail = (MODE == FIFO_FWFT) ? valid_q : ~empty_q;
    rd_ok      = act & bus.read & head_avail;
    wr_ok      = act & bus.write & (~full_q | rd_ok);
    if (MODE == FIFO_FWFT) ram_rd_en = act & (ram_cnt_q != '0) & (~valid_q | rd_ok);
    else                   ram_rd_en = rd_ok;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ram_cnt_d = ram_cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    valid_d   = valid_q;
    loaded_d  = loaded_q;
    if (bus.enable) begin
      if (bus.flush) begin
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        count_d   = '0;
        ram_cnt_d = '0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        valid_d   = 1'b0;
      end else begin
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_ok);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(ram_rd_en);
        count_d   = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        ram_cnt_d = ram_cnt_q + CNT_W'(wr_ok) - CNT_W'(ram_rd_en);
        ovf_d     = ovf_q | (bus.write & ~wr_ok);
        unf_d     = unf_q | (bus.read & ~rd_ok);
        loaded_d  = loaded_q | ram_rd_en;
        if (MODE == FIFO_FWFT) valid_d = ram_rd_en | (valid_q & ~rd_ok);
        else                   valid_d = rd_ok;
      end
    end
    full_d   = (count_d == CNT_W'(DEPTH));
    afull_d  = (count_d >= CNT_W'(ALMOST_FULL_LEVEL));
    aempty_d = (count_d <= CNT_W'(ALMOST_EMPTY_LEVEL));
    empty_d  = (MODE == FIFO_FWFT) ? ~valid_d : (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ram_cnt_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      valid_q   <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      valid_q   <= valid_d;
      loaded_q  <= loaded_d;
    end
  end

  fifo_ram_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(bus.data_in),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_q)
  );

  // The RAM has no reset, so data_out reads as zero until the first word is fetched.
  assign bus.data_out     = loaded_q ? ram_q : '0;
  assign bus.valid        = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_ram_param.sv
// tb/tb_fifo_ram_param.sv - directed self-checking bench for fifo_ram_param (standard and FWFT)
module tb_fifo_ram_param;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fifo_ram_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s_if ();
  fifo_ram_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f_if ();

  fifo_ram_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(4), .FWFT(0)
  ) u_std (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (s_if.slave)
  );

  fifo_ram_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(4), .FWFT(1)
  ) u_fwft (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (f_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    s_if.write   = 1'b1;
    s_if.data_in = d;
    tick();
    s_if.write   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    s_if.read = 1'b1;
    tick();
    s_if.read = 1'b0;
    check({tag, " data"}, 32'(s_if.data_out), 32'(exp));
    check({tag, " valid"}, 32'(s_if.valid), 32'd1);
  endtask

  task automatic do_flush();
    s_if.flush = 1'b1;
    tick();
    s_if.flush = 1'b0;
  endtask

  logic [7:0] basic_vec [0:10];

  initial begin
    basic_vec = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255, 8'd112, 8'd44};
    reset_n = 1'b0;
    s_if.enable = 1'b1; s_if.flush = 1'b0; s_if.write = 1'b0; s_if.read = 1'b0; s_if.data_in = '0;
    f_if.enable = 1'b1; f_if.flush = 1'b0; f_if.write = 1'b0; f_if.read = 1'b0; f_if.data_in = '0;
    #12 reset_n = 1'b1;
    tick();

    check("rst count", 32'(s_if.count), 32'd0);
    check("rst empty", 32'(s_if.empty), 32'd1);
    check("rst aempty", 32'(s_if.almost_empty), 32'd1);
    check("rst full", 32'(s_if.full), 32'd0);
    check("rst afull", 32'(s_if.almost_full), 32'd0);
    check("rst valid", 32'(s_if.valid), 32'd0);
    check("rst data", 32'(s_if.data_out), 32'd0);
    check("rst flags", {30'd0, s_if.overflow, s_if.underflow}, 32'd0);

    // basic ordering
    for (int i = 0; i < 11; i++) push(basic_vec[i]);
    check("basic count11", 32'(s_if.count), 32'd11);
    check("basic afull11", 32'(s_if.almost_full), 32'd0);
    for (int i = 0; i < 11; i++) pop_check($sformatf("basic pop%0d", i), basic_vec[i]);
    tick();
    check("basic valid pulse", 32'(s_if.valid), 32'd0);
    check("basic count0", 32'(s_if.count), 32'd0);
    check("basic empty", 32'(s_if.empty), 32'd1);
    check("basic flags", {30'd0, s_if.overflow, s_if.underflow}, 32'd0);

    // full and overflow
    for (int i = 1; i <= 16; i++) begin
      push(8'h08);
      if (i == 11) check("ovf afull11", 32'(s_if.almost_full), 32'd0);
      if (i == 12) check("ovf afull12", 32'(s_if.almost_full), 32'd1);
      if (i == 15) check("ovf full15", 32'(s_if.full), 32'd0);
    end
    check("ovf full16", 32'(s_if.full), 32'd1);
    check("ovf ovf before", 32'(s_if.overflow), 32'd0);
    for (int i = 0; i < 3; i++) push(8'h09);
    check("ovf count", 32'(s_if.count), 32'd16);
    check("ovf overflow", 32'(s_if.overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf pop%0d", i), 8'h08);
    check("ovf empty", 32'(s_if.empty), 32'd1);
    check("ovf sticky", 32'(s_if.overflow), 32'd1);
    do_flush();
    check("ovf flush clr", 32'(s_if.overflow), 32'd0);

    // enable gating
    s_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.write = 1'b1; s_if.read = 1'b1;
      s_if.data_in = (i == 0) ? 8'd2 : (i == 1) ? 8'd3 : (i == 2) ? 8'd5 : 8'd7;
      tick();
    end
    s_if.write = 1'b0; s_if.read = 1'b0;
    check("en count", 32'(s_if.count), 32'd0);
    check("en empty", 32'(s_if.empty), 32'd1);
    check("en flags", {30'd0, s_if.overflow, s_if.underflow}, 32'd0);
    s_if.enable = 1'b1;
    s_if.read = 1'b1;
    tick();
    s_if.read = 1'b0;
    check("en underflow", 32'(s_if.underflow), 32'd1);
    check("en valid", 32'(s_if.valid), 32'd0);
    do_flush();
    check("en flush clr", 32'(s_if.underflow), 32'd0);

    // simultaneous read+write at full and empty
    for (int i = 0; i < 16; i++) push(8'(i));
    s_if.write = 1'b1; s_if.read = 1'b1; s_if.data_in = 8'hAA;
    tick();
    s_if.write = 1'b0; s_if.read = 1'b0;
    check("sim full count", 32'(s_if.count), 32'd16);
    check("sim full ovf", 32'(s_if.overflow), 32'd0);
    check("sim full data", 32'(s_if.data_out), 32'h00);
    for (int i = 1; i < 16; i++) pop_check($sformatf("sim pop%0d", i), 8'(i));
    pop_check("sim pop aa", 8'hAA);
    check("sim empty", 32'(s_if.empty), 32'd1);
    s_if.write = 1'b1; s_if.read = 1'b1; s_if.data_in = 8'h55;
    tick();
    s_if.write = 1'b0; s_if.read = 1'b0;
    check("sim empty count", 32'(s_if.count), 32'd1);
    check("sim empty unf", 32'(s_if.underflow), 32'd1);
    check("sim empty valid", 32'(s_if.valid), 32'd0);
    pop_check("sim pop 55", 8'h55);

    // flush and asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    check("fl count5", 32'(s_if.count), 32'd5);
    s_if.flush = 1'b1; s_if.write = 1'b1; s_if.read = 1'b1; s_if.data_in = 8'hEE;
    tick();
    s_if.flush = 1'b0; s_if.write = 1'b0; s_if.read = 1'b0;
    check("fl count0", 32'(s_if.count), 32'd0);
    check("fl empty", 32'(s_if.empty), 32'd1);
    check("fl flags", {30'd0, s_if.overflow, s_if.underflow}, 32'd0);
    check("fl valid", 32'(s_if.valid), 32'd0);
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
    pop_check("fl pop40", 8'h40);
    #2 reset_n = 1'b0;
    #1;
    check("arst count", 32'(s_if.count), 32'd0);
    check("arst empty", 32'(s_if.empty), 32'd1);
    check("arst data", 32'(s_if.data_out), 32'd0);
    check("arst valid", 32'(s_if.valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    push(8'h77);
    check("arst after cnt", 32'(s_if.count), 32'd1);
    pop_check("arst pop77", 8'h77);

    // FWFT
    f_if.write = 1'b1; f_if.data_in = 8'h11;
    tick();
    f_if.write = 1'b0;
    check("fwft valid c1", 32'(f_if.valid), 32'd0);
    check("fwft empty c1", 32'(f_if.empty), 32'd1);
    check("fwft count c1", 32'(f_if.count), 32'd1);
    tick();
    check("fwft valid c2", 32'(f_if.valid), 32'd1);
    check("fwft data c2", 32'(f_if.data_out), 32'h11);
    check("fwft empty c2", 32'(f_if.empty), 32'd0);
    f_if.write = 1'b1; f_if.data_in = 8'h22;
    tick();
    f_if.data_in = 8'h33;
    tick();
    f_if.write = 1'b0;
    check("fwft count3", 32'(f_if.count), 32'd3);
    check("fwft head 11", 32'(f_if.data_out), 32'h11);
    f_if.read = 1'b1;
    tick();
    check("fwft head 22", 32'(f_if.data_out), 32'h22);
    check("fwft valid 22", 32'(f_if.valid), 32'd1);
    tick();
    check("fwft head 33", 32'(f_if.data_out), 32'h33);
    check("fwft valid 33", 32'(f_if.valid), 32'd1);
    tick();
    f_if.read = 1'b0;
    check("fwft end valid", 32'(f_if.valid), 32'd0);
    check("fwft end empty", 32'(f_if.empty), 32'd1);
    check("fwft end count", 32'(f_if.count), 32'd0);
    check("fwft end unf", 32'(f_if.underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
